// File: rtl/clock_edge_monitor_pkg.sv
// ---------------------------------------------------------------------------
// clock_edge_monitor_pkg
// Shared definitions for the slow-clock edge monitor:
//   state_e    - monitor FSM encodings (2 bits)
//   ZeroWord   - all-zero 32-bit word
//   CNT_MAX    - saturation value of the edge-to-edge counter
//   window_match() - inclusive tolerance-window compare done in 33 bits
// ---------------------------------------------------------------------------
package clock_edge_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;

  // True when val lies in [centre-tol, centre+tol]. The arithmetic is widened
  // to 33 bits so centre+tol cannot wrap, and the lower bound clamps at zero
  // when tol exceeds centre.
  function automatic logic window_match(input logic [31:0] val,
                                        input logic [31:0] centre,
                                        input logic [31:0] tol);
    logic [32:0] v_w;
    logic [32:0] lo_w;
    logic [32:0] hi_w;
    v_w  = {1'b0, val};
    hi_w = {1'b0, centre} + {1'b0, tol};
    if (tol > centre) begin
      lo_w = 33'd0;
    end else begin
      lo_w = {1'b0, centre} - {1'b0, tol};
    end
    return (v_w >= lo_w) && (v_w <= hi_w);
  endfunction

endpackage

// File: rtl/clock_edge_monitor_if.sv
// ---------------------------------------------------------------------------
// clock_edge_monitor_if
// Bundles the monitor's functional signals.
//   clk_in, en               : driven by the master (source side)
//   step, edge_any           : 1-cycle strobes from the monitor
//   half_period, locked,
//   lost, err_cnt            : measurement and status from the monitor
// The monitor itself connects through the slave modport.
// ---------------------------------------------------------------------------
interface clock_edge_monitor_if;
  logic        clk_in;
  logic        en;
  logic        step;
  logic        edge_any;
  logic [31:0] half_period;
  logic        locked;
  logic        lost;
  logic [7:0]  err_cnt;

  modport master (
    output clk_in, en,
    input  step, edge_any, half_period, locked, lost, err_cnt
  );

  modport slave (
    input  clk_in, en,
    output step, edge_any, half_period, locked, lost, err_cnt
  );
endinterface

// File: rtl/clock_edge_monitor_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk domain through SYNC_STAGES flops,
// keeps one 'prev' flop behind the chain, and emits registered 1-cycle strobes.
// A transition first sampled at clk edge k shows on the strobes for exactly the
// cycle following edge k+SYNC_STAGES.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   d_in       - asynchronous input level
//   rise, fall - registered strobe per rising / falling transition
//   toggle     - registered strobe per either transition
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise,
  output logic fall,
  output logic toggle
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   toggle_q;
  logic                   toggle_d;

  // Next-state for the synchronizer chain, prev flop and strobe registers.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d   = sync_q[SYNC_STAGES-1];
    rise_d   = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d   = ~sync_q[SYNC_STAGES-1] & prev_q;
    toggle_d = sync_q[SYNC_STAGES-1] ^ prev_q;
  end

  // Synchronizer, prev and strobe flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign rise   = rise_q;
  assign fall   = fall_q;
  assign toggle = toggle_q;

endmodule

// File: rtl/clock_edge_monitor.sv
// ---------------------------------------------------------------------------
// clock_edge_monitor
// Receive-side monitor for a slow clock: synchronizes clk_in, emits edge
// strobes, measures edge-to-edge distance in clk cycles, and tracks lock
// against EXP_HALF +/- TOL.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   mon      - slave modport: clk_in/en in; step, edge_any, half_period,
//              locked, lost, err_cnt out (all registered)
// ---------------------------------------------------------------------------
module clock_edge_monitor
  import clock_edge_monitor_pkg::*;
#(
  parameter logic [31:0] EXP_HALF    = 32'd25_000_000,
  parameter logic [31:0] TOL         = 32'd1024,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_edge_monitor_if.slave   mon
);

  // Upper window bound, also the loss threshold (no wrap in 33 bits).
  localparam logic [32:0] HI_BOUND = {1'b0, EXP_HALF} + {1'b0, TOL};
  localparam logic [3:0]  LOCK_TGT = LOCK_COUNT[3:0];

  logic        rise_s;
  logic        fall_s;
  logic        toggle_s;
  logic        edge_s;
  logic        match_s;
  logic        timeout_s;

  state_e      state_q,       state_d;
  logic [31:0] cnt_q,         cnt_d;
  logic [3:0]  good_q,        good_d;
  logic        start_q,       start_d;
  logic [31:0] half_period_q, half_period_d;
  logic        locked_q,      locked_d;
  logic        lost_q,        lost_d;
  logic [7:0]  err_cnt_q,     err_cnt_d;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_in   (mon.clk_in),
    .rise   (rise_s),
    .fall   (fall_s),
    .toggle (toggle_s)
  );

  // The measurement event is either directional strobe; this equals toggle_s,
  // which drives edge_any.
  assign edge_s    = rise_s | fall_s;
  assign match_s   = window_match(cnt_q, EXP_HALF, TOL);
  assign timeout_s = ({1'b0, cnt_q} > HI_BOUND);

  // Edge-to-edge counter, measurement and lock FSM next-state logic.
  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    start_d       = start_q;
    half_period_d = half_period_q;
    locked_d      = locked_q;
    lost_d        = lost_q;
    err_cnt_d     = err_cnt_q;

    // Counter restarts at 1 on an edge so cnt equals the edge spacing at the
    // next edge; it saturates rather than wraps when clk_in stops.
    if (edge_s) begin
      cnt_d = 32'd1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end

    if (!mon.en) begin
      state_d  = ST_IDLE;
      good_d   = 4'd0;
      start_d  = 1'b0;
      locked_d = 1'b0;
      lost_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
          start_d = 1'b0;
          good_d  = 4'd0;
        end

        ST_ACQUIRE: begin
          if (edge_s) begin
            if (start_q) begin
              half_period_d = cnt_q;
              if (match_s) begin
                good_d = good_q + 4'd1;
                if ((good_q + 4'd1) == LOCK_TGT) begin
                  state_d  = ST_LOCKED;
                  locked_d = 1'b1;
                end else begin
                  state_d = ST_ACQUIRE;
                end
              end else begin
                good_d = 4'd0;
              end
            end else begin
              // First edge after entering ACQUIRE only opens the measurement.
              start_d = 1'b1;
            end
          end else if (timeout_s) begin
            state_d = ST_LOST;
            lost_d  = 1'b1;
            good_d  = 4'd0;
          end else begin
            state_d = ST_ACQUIRE;
          end
        end

        ST_LOCKED: begin
          // Edge has priority over the timeout when both land together.
          if (edge_s) begin
            half_period_d = cnt_q;
            if (!match_s) begin
              state_d  = ST_ACQUIRE;
              good_d   = 4'd0;
              locked_d = 1'b0;
              if (err_cnt_q == 8'hFF) begin
                err_cnt_d = err_cnt_q;
              end else begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end else begin
              state_d = ST_LOCKED;
            end
          end else if (timeout_s) begin
            state_d  = ST_LOST;
            lost_d   = 1'b1;
            locked_d = 1'b0;
            good_d   = 4'd0;
          end else begin
            state_d = ST_LOCKED;
          end
        end

        ST_LOST: begin
          // The recovering edge becomes the start of the next measurement.
          if (edge_s) begin
            state_d = ST_ACQUIRE;
            lost_d  = 1'b0;
            start_d = 1'b1;
            good_d  = 4'd0;
          end else begin
            state_d = ST_LOST;
          end
        end

        default: begin
          state_d  = ST_IDLE;
          good_d   = 4'd0;
          start_d  = 1'b0;
          locked_d = 1'b0;
          lost_d   = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= ZeroWord;
      good_q        <= 4'd0;
      start_q       <= 1'b0;
      half_period_q <= ZeroWord;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      good_q        <= good_d;
      start_q       <= start_d;
      half_period_q <= half_period_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign mon.step        = rise_s;
  assign mon.edge_any    = toggle_s;
  assign mon.half_period = half_period_q;
  assign mon.locked      = locked_q;
  assign mon.lost        = lost_q;
  assign mon.err_cnt     = err_cnt_q;

endmodule
